// File: rtl/envelope_ctrl.sv
// Envelope register block: NRx2/NRx4 writes, trigger pulse, channel enable, 512 Hz frame sequencer ticks.
// Optional feature: define ENVELOPE_CTRL_SHADOW_EN to latch volume/add/period only on trigger.
module envelope_ctrl #(
   parameter int unsigned CLK_DIV = 8192
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic       wr_addr,
   input  logic [7:0] wr_data,
   output logic [3:0] starting_volume,
   output logic       envelope_add,
   output logic [2:0] period,
   output logic       trigger,
   output logic       dac_enable,
   output logic       channel_enable,
   output logic       env_tick,
   output logic       length_tick
);

   localparam int DIV_W = 16;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [7:0]       nrx2_q, nrx2_d;
   logic             trigger_q, trigger_d;
   logic             channel_enable_q, channel_enable_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       step_q, step_d;
   logic             env_tick_q, env_tick_d;
   logic             length_tick_q, length_tick_d;
   logic             nrx2_wr;
   logic             nrx4_trig;
   logic             wrap;

   assign dac_enable = |nrx2_q[7:3];

   always_comb begin
      nrx2_wr   = wr_en && !wr_addr;
      nrx4_trig = wr_en && wr_addr && wr_data[7];
      nrx2_d    = nrx2_wr ? wr_data : nrx2_q;
      // A trigger is only launched against the DAC state stored before this edge.
      trigger_d = nrx4_trig && dac_enable;

      channel_enable_d = channel_enable_q;
      if (nrx2_wr && (wr_data[7:3] == 5'd0)) begin
         channel_enable_d = 1'b0;
      end else if (trigger_d) begin
         channel_enable_d = 1'b1;
      end

      wrap          = (div_q == DIV_LAST);
      div_d         = wrap ? '0 : div_q + 1'b1;
      step_d        = wrap ? step_q + 3'd1 : step_q;
      // Ticks are flagged on the same edge the step counter moves into the new step.
      length_tick_d = wrap && !step_d[0];
      env_tick_d    = wrap && (step_q == 3'd6);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nrx2_q           <= '0;
         trigger_q        <= 1'b0;
         channel_enable_q <= 1'b0;
         div_q            <= '0;
         step_q           <= '0;
         env_tick_q       <= 1'b0;
         length_tick_q    <= 1'b0;
      end else begin
         nrx2_q           <= nrx2_d;
         trigger_q        <= trigger_d;
         channel_enable_q <= channel_enable_d;
         div_q            <= div_d;
         step_q           <= step_d;
         env_tick_q       <= env_tick_d;
         length_tick_q    <= length_tick_d;
      end
   end

`ifdef ENVELOPE_CTRL_SHADOW_EN
   logic [7:0] shadow_q, shadow_d;

   always_comb begin
      shadow_d = trigger_d ? nrx2_q : shadow_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_q <= '0;
      end else begin
         shadow_q <= shadow_d;
      end
   end

   assign starting_volume = shadow_q[7:4];
   assign envelope_add    = shadow_q[3];
   assign period          = shadow_q[2:0];
`else
   assign starting_volume = nrx2_q[7:4];
   assign envelope_add    = nrx2_q[3];
   assign period          = nrx2_q[2:0];
`endif

   assign trigger        = trigger_q;
   assign channel_enable = channel_enable_q;
   assign env_tick       = env_tick_q;
   assign length_tick    = length_tick_q;

endmodule

// File: tb/tb_envelope_ctrl.sv
// Directed table-driven bench for envelope_ctrl with CLK_DIV=4; honours ENVELOPE_CTRL_SHADOW_EN.
module tb_envelope_ctrl;

   localparam int unsigned CLK_DIV = 4;
`ifdef ENVELOPE_CTRL_SHADOW_EN
   localparam bit SHADOW = 1'b1;
`else
   localparam bit SHADOW = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       wr_en;
   logic       wr_addr;
   logic [7:0] wr_data;
   logic [3:0] starting_volume;
   logic       envelope_add;
   logic [2:0] period;
   logic       trigger;
   logic       dac_enable;
   logic       channel_enable;
   logic       env_tick;
   logic       length_tick;

   int errors = 0;
   int checks = 0;

   envelope_ctrl #(.CLK_DIV(CLK_DIV)) dut (
      .clk             (clk),
      .reset           (reset),
      .wr_en           (wr_en),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data),
      .starting_volume (starting_volume),
      .envelope_add    (envelope_add),
      .period          (period),
      .trigger         (trigger),
      .dac_enable      (dac_enable),
      .channel_enable  (channel_enable),
      .env_tick        (env_tick),
      .length_tick     (length_tick)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr_en;
      logic        wr_addr;
      logic [7:0]  wr_data;
      logic [10:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[19];

   // expected packing: {volume, add, period, trigger, dac_enable, channel_enable}
   function automatic logic [10:0] mk(input logic [3:0] vol, input logic add, input logic [2:0] per,
                                      input logic trig, input logic dac, input logic ch);
      return {vol, add, per, trig, dac, ch};
   endfunction

   function automatic logic [10:0] sel(input logic [10:0] plain, input logic [10:0] shadow);
      return SHADOW ? shadow : plain;
   endfunction

   function automatic logic [10:0] outs();
      return {starting_volume, envelope_add, period, trigger, dac_enable, channel_enable};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_ticks(input int n);
      logic [1:0] exp;
      exp = {(n % 8) == 0, (n % 32) == 28};
      check($sformatf("ticks_edge%0d", n), {30'd0, length_tick, env_tick}, {30'd0, exp});
   endtask

   task automatic set_vec(input int i, input logic en, input logic addr, input logic [7:0] data,
                          input logic [10:0] exp, input string name);
      vecs[i].wr_en   = en;
      vecs[i].wr_addr = addr;
      vecs[i].wr_data = data;
      vecs[i].exp     = exp;
      vecs[i].name    = name;
   endtask

   task automatic drive(input logic en, input logic addr, input logic [7:0] data);
      wr_en   = en;
      wr_addr = addr;
      wr_data = data;
   endtask

   initial begin
      set_vec(0,  1, 0, 8'hF1, sel(mk(4'hF,0,3'd1,0,1,0), mk(4'h0,0,3'd0,0,1,0)), "nrx2_f1");
      set_vec(1,  0, 0, 8'h00, sel(mk(4'hF,0,3'd1,0,1,0), mk(4'h0,0,3'd0,0,1,0)), "idle_after_f1");
      set_vec(2,  1, 0, 8'h8B, sel(mk(4'h8,1,3'd3,0,1,0), mk(4'h0,0,3'd0,0,1,0)), "nrx2_8b");
      set_vec(3,  1, 1, 8'h80, mk(4'h8,1,3'd3,1,1,1),                            "trig_8b");
      set_vec(4,  0, 0, 8'h00, mk(4'h8,1,3'd3,0,1,1),                            "trig_one_cycle");
      set_vec(5,  1, 0, 8'h00, sel(mk(4'h0,0,3'd0,0,0,0), mk(4'h8,1,3'd3,0,0,0)), "nrx2_00_clear");
      set_vec(6,  1, 1, 8'h80, sel(mk(4'h0,0,3'd0,0,0,0), mk(4'h8,1,3'd3,0,0,0)), "trig_dac_off");
      set_vec(7,  0, 0, 8'h00, sel(mk(4'h0,0,3'd0,0,0,0), mk(4'h8,1,3'd3,0,0,0)), "idle_dac_off");
      set_vec(8,  1, 0, 8'hF0, sel(mk(4'hF,0,3'd0,0,1,0), mk(4'h8,1,3'd3,0,1,0)), "nrx2_f0");
      set_vec(9,  1, 1, 8'h80, mk(4'hF,0,3'd0,1,1,1),                            "trig_b2b_1");
      set_vec(10, 1, 1, 8'h80, mk(4'hF,0,3'd0,1,1,1),                            "trig_b2b_2");
      set_vec(11, 0, 0, 8'h00, mk(4'hF,0,3'd0,0,1,1),                            "idle_after_b2b");
      set_vec(12, 1, 1, 8'h7F, mk(4'hF,0,3'd0,0,1,1),                            "nrx4_7f");
      set_vec(13, 1, 1, 8'h00, mk(4'hF,0,3'd0,0,1,1),                            "nrx4_00");
      set_vec(14, 1, 0, 8'h07, sel(mk(4'h0,0,3'd7,0,0,0), mk(4'hF,0,3'd0,0,0,0)), "nrx2_07_clear");
      set_vec(15, 1, 0, 8'h08, sel(mk(4'h0,1,3'd0,0,1,0), mk(4'hF,0,3'd0,0,1,0)), "nrx2_08_dac");
      set_vec(16, 1, 1, 8'hFF, mk(4'h0,1,3'd0,1,1,1),                            "trig_ff");
      set_vec(17, 1, 0, 8'hA5, sel(mk(4'hA,0,3'd5,0,1,1), mk(4'h0,1,3'd0,0,1,1)), "nrx2_a5_keep");
      set_vec(18, 0, 0, 8'h00, sel(mk(4'hA,0,3'd5,0,1,1), mk(4'h0,1,3'd0,0,1,1)), "no_write");

      reset = 1'b1;
      drive(0, 0, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", {19'd0, outs(), length_tick, env_tick}, 32'd0);
      reset = 1'b0;

      // free run after reset
      for (int n = 1; n <= 64; n++) begin
         @(posedge clk);
         #1;
         check_ticks(n);
      end

      for (int i = 0; i < 19; i++) begin
         drive(vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data);
         @(posedge clk);
         #1;
         check(vecs[i].name, {21'd0, outs()}, {21'd0, vecs[i].exp});
      end
      drive(0, 0, 8'h00);

      // mid-count reset with live channel state
      reset = 1'b1;
      #2;
      reset = 1'b0;
      for (int n = 1; n <= 13; n++) begin
         if (n == 1) drive(1, 0, 8'hC3);
         else if (n == 2) drive(1, 1, 8'h80);
         else drive(0, 0, 8'h00);
         @(posedge clk);
         #1;
         check_ticks(n);
      end
      check("pre_reset_live", {21'd0, outs()}, {21'd0, mk(4'hC,0,3'd3,0,1,1)});
      reset = 1'b1;
      #1;
      check("reset_async", {19'd0, outs(), length_tick, env_tick}, 32'd0);
      for (int k = 0; k < 2; k++) begin
         drive(1, k[0], 8'hF0);
         @(posedge clk);
         #1;
         check($sformatf("reset_hold%0d", k), {19'd0, outs(), length_tick, env_tick}, 32'd0);
      end
      drive(0, 0, 8'h00);
      reset = 1'b0;
      for (int n = 1; n <= 32; n++) begin
         @(posedge clk);
         #1;
         check_ticks(n);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
